alu_share_arbiter: RTL and testbench

//  Shares one combinational ALU+decoder (uladec: aluop, funct, a, b -> result) between two requesters.

---
 rtl/alu_share_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// alu_share_arbiter : round-robin sharing of one combinational ALU between two
//                     requesters; operand capture, one execute cycle, held result
// Revision 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_aluop0,
  input  logic [1:0]       req_aluop1,
  input  logic [5:0]       req_funct0,
  input  logic [5:0]       req_funct1,
  input  logic [W-1:0]     req_a0,
  input  logic [W-1:0]     req_a1,
  input  logic [W-1:0]     req_b0,
  input  logic [W-1:0]     req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [W-1:0]     rsp_data,
  output logic             rsp_zero,
  output logic [1:0]       alu_aluop,
  output logic [5:0]       alu_funct,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  input  logic [W-1:0]     alu_result,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q,    state_d;
  logic             last_q,     last_d;
  logic             owner_q,    owner_d;
  logic [1:0]       aluop_q,    aluop_d;
  logic [5:0]       funct_q,    funct_d;
  logic [W-1:0]     a_q,        a_d;
  logic [W-1:0]     b_q,        b_d;
  logic [W-1:0]     result_q,   result_d;
  logic [CNT_W-1:0] ops_done_q, ops_done_d;
  logic             gnt;

  // Tie goes to the requester that was not served last; otherwise the lone valid one.
  assign gnt = (req_valid == 2'b11) ? ~last_q : ~req_valid[0];

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    aluop_d    = aluop_q;
    funct_d    = funct_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    ops_done_d = ops_done_q;
    req_ready  = 2'b00;
    rsp_valid  = 2'b00;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready[gnt] = 1'b1;
          owner_d        = gnt;
          aluop_d        = gnt ? req_aluop1 : req_aluop0;
          funct_d        = gnt ? req_funct1 : req_funct0;
          a_d            = gnt ? req_a1     : req_a0;
          b_d            = gnt ? req_b1     : req_b0;
          state_d        = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_result;
        state_d  = RESP;
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) begin
          last_d     = owner_q;
          ops_done_d = ops_done_q + CNT_W'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      aluop_q    <= '0;
      funct_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      ops_done_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      aluop_q    <= aluop_d;
      funct_q    <= funct_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      ops_done_q <= ops_done_d;
    end
  end

  assign alu_aluop = aluop_q;
  assign alu_funct = funct_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rsp_data  = result_q;
  assign rsp_zero  = (result_q == '0);
  assign busy      = (state_q != IDLE);
  assign ops_done  = ops_done_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// Scoreboard bench for alu_share_arbiter; a small uladec model drives alu_result.
module tb_alu_share_arbiter;
  localparam int W     = 32;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid, req_ready;
  logic [1:0]       req_aluop0, req_aluop1;
  logic [5:0]       req_funct0, req_funct1;
  logic [W-1:0]     req_a0, req_a1, req_b0, req_b1;
  logic [1:0]       rsp_valid, rsp_ready;
  logic [W-1:0]     rsp_data;
  logic             rsp_zero;
  logic [1:0]       alu_aluop;
  logic [5:0]       alu_funct;
  logic [W-1:0]     alu_a, alu_b, alu_result;
  logic             busy;
  logic [CNT_W-1:0] ops_done;

  always #5 clk = ~clk;

  alu_share_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_aluop0(req_aluop0), .req_aluop1(req_aluop1),
    .req_funct0(req_funct0), .req_funct1(req_funct1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .alu_aluop(alu_aluop), .alu_funct(alu_funct), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .busy(busy), .ops_done(ops_done)
  );

  // MIPS-style ALU decoder: 00 add, 01 sub, 10 decode funct.
  function automatic logic [W-1:0] uladec(input logic [1:0] op, input logic [5:0] fn,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    case (op)
      2'b00: r = a + b;
      2'b01: r = a - b;
      2'b10: begin
        case (fn)
          6'b100000: r = a + b;
          6'b100010: r = a - b;
          6'b100100: r = a & b;
          6'b100101: r = a | b;
          6'b101010: r = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
          default:   r = '0;
        endcase
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb alu_result = uladec(alu_aluop, alu_funct, alu_a, alu_b);

  typedef struct {
    logic         id;
    logic [W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic id, input logic [W-1:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every response handshake is matched against the head of the scoreboard.
  always @(negedge clk) begin
    logic [1:0] hs;
    exp_t       e;
    hs = rsp_valid & rsp_ready;
    if (reset === 1'b1 && hs != 2'b00) begin
      if (exp_q.size() == 0) begin
        chk("unexpected rsp", {62'd0, hs}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp owner", {62'd0, hs}, e.id ? 64'd2 : 64'd1);
        chk("rsp data", {32'd0, rsp_data}, {32'd0, e.data});
        chk("rsp zero", {63'd0, rsp_zero}, {63'd0, (e.data == '0)});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cyc;
    reset = 1'b0;
    req_valid = 2'b00;
    req_aluop0 = '0; req_aluop1 = '0; req_funct0 = '0; req_funct1 = '0;
    req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
    rsp_ready = 2'b11;

    // Reset state
    repeat (2) step();
    @(negedge clk);
    chk("reset req_ready", {62'd0, req_ready}, 64'd0);
    chk("reset rsp_valid", {62'd0, rsp_valid}, 64'd0);
    chk("reset ops_done", {62'd0, ops_done}, 64'd0);
    chk("reset alu_a", {32'd0, alu_a}, 64'd0);
    chk("reset busy", {63'd0, busy}, 64'd0);

    // Reset asserted while in EXEC drops the operation
    step();
    reset = 1'b1;
    req_aluop0 = 2'b10; req_funct0 = 6'b100000; req_a0 = 32'd1; req_b0 = 32'd1;
    req_valid = 2'b01;
    @(negedge clk);
    chk("abort grant", {62'd0, req_ready}, 64'd1);
    step();
    req_valid = 2'b00;
    reset = 1'b0;
    @(negedge clk);
    chk("abort in exec", {63'd0, busy}, 64'd1);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("abort busy", {63'd0, busy}, 64'd0);
    chk("abort rsp_valid", {62'd0, rsp_valid}, 64'd0);
    chk("abort ops_done", {62'd0, ops_done}, 64'd0);
    repeat (3) step();
    @(negedge clk);
    chk("abort no rsp", {62'd0, rsp_valid}, 64'd0);

    // Single requester 0: 5 + 7
    step();
    req_aluop0 = 2'b10; req_funct0 = 6'b100000; req_a0 = 32'd5; req_b0 = 32'd7;
    req_valid = 2'b01;
    push(1'b0, 32'd12);
    @(negedge clk);
    chk("single ready", {62'd0, req_ready}, 64'd1);
    step();
    req_valid = 2'b00;
    @(negedge clk);
    chk("single exec rsp_valid", {62'd0, rsp_valid}, 64'd0);
    chk("single alu_a", {32'd0, alu_a}, 64'd5);
    chk("single alu_b", {32'd0, alu_b}, 64'd7);
    step();
    @(negedge clk);
    chk("single rsp_valid", {62'd0, rsp_valid}, 64'd1);
    chk("single rsp_data", {32'd0, rsp_data}, 64'd12);
    chk("single rsp_zero", {63'd0, rsp_zero}, 64'd0);
    step();
    @(negedge clk);
    chk("single ops_done", {62'd0, ops_done}, 64'd1);
    chk("single idle", {63'd0, busy}, 64'd0);

    // Fresh reset, then both requesters contend continuously
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    req_aluop0 = 2'b10; req_funct0 = 6'b100010; req_a0 = 32'd9; req_b0 = 32'd9;
    req_aluop1 = 2'b10; req_funct1 = 6'b101010; req_a1 = 32'd3; req_b1 = 32'd8;
    req_valid = 2'b11;
    push(1'b0, 32'd0); push(1'b1, 32'd1); push(1'b0, 32'd0); push(1'b1, 32'd1);
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 40) begin
      @(negedge clk);
      if ((req_ready & req_valid) != 2'b00) begin
        chk("grant order", {62'd0, req_ready}, (n % 2 == 0) ? 64'd1 : 64'd2);
        n++;
      end
      step();
      cyc++;
    end
    req_valid = 2'b00;
    if (n < 4) chk("grant timeout", 64'(n), 64'd4);
    repeat (4) step();
    @(negedge clk);
    chk("contend ops_done", {62'd0, ops_done}, 64'd0);
    chk("contend idle", {63'd0, busy}, 64'd0);

    // Owner withholds ack; other requester's ack ignored, no new grant
    step();
    rsp_ready = 2'b01;
    req_aluop1 = 2'b00; req_funct1 = 6'd0; req_a1 = 32'd100; req_b1 = 32'd23;
    req_valid = 2'b10;
    push(1'b1, 32'd123);
    @(negedge clk);
    chk("stall grant1", {62'd0, req_ready}, 64'd2);
    step();
    req_aluop0 = 2'b00; req_funct0 = 6'd0; req_a0 = 32'd2; req_b0 = 32'd3;
    req_valid = 2'b01;
    push(1'b0, 32'd5);
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall rsp_valid", {62'd0, rsp_valid}, 64'd2);
      chk("stall rsp_data", {32'd0, rsp_data}, 64'd123);
      chk("stall no grant", {62'd0, req_ready}, 64'd0);
      step();
    end
    rsp_ready = 2'b11;
    step();
    @(negedge clk);
    chk("wrap ops_done", {62'd0, ops_done}, 64'd1);
    chk("post-stall grant0", {62'd0, req_ready}, 64'd1);
    step();
    req_valid = 2'b00;
    repeat (3) step();
    @(negedge clk);
    chk("final ops_done", {62'd0, ops_done}, 64'd2);
    chk("scoreboard empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
